exec_sequencer: RTL



---
 rtl/exec_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer -- multi-cycle fetch/read/execute/writeback sequencer for the
// 16-bit CPU. It drives a 4x16 register file that has a combinational read
// path. Only one instruction is in flight at a time.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   instr_valid/instr    instruction word offered by the source
//   instr_ready          high in FETCH; a word is accepted on valid && ready
//   rf_read_address1/2   operand selects, taken from ir[9:8] and ir[7:6]
//   rf_data_out1/2       operand data returned by the register file
//   rf_enabling          one-cycle write strobe, asserted in WB
//   rf_write_address     destination register, taken from ir[11:10]
//   rf_data_in           writeback data (the result register)
//   zero_flag/carry_flag result flags of the last writing instruction
//   pc                   count of accepted instructions, wraps at 8 bits
//   busy                 high in READ, EXEC and WB
//   halted               high once HALT has executed, until reset
//   illegal              high for the EXEC cycle of an undefined opcode
//
// Build option: EXEC_SEQUENCER_SHIFT_EN enables SHL (opcode 9) and SHR
// (opcode A). Without it, both opcodes are illegal.
module exec_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   output logic [1:0]  rf_read_address1,
   output logic [1:0]  rf_read_address2,
   input  logic [15:0] rf_data_out1,
   input  logic [15:0] rf_data_out2,
   output logic        rf_enabling,
   output logic [1:0]  rf_write_address,
   output logic [15:0] rf_data_in,
   output logic        zero_flag,
   output logic        carry_flag,
   output logic [7:0]  pc,
   output logic        busy,
   output logic        halted,
   output logic        illegal
);

   typedef enum logic [2:0] {FETCH, READ, EXEC, WB, HALTED} state_t;

   state_t      state, state_nxt;
   logic [15:0] ir, op_a, op_b, result;
   logic [3:0]  opc;
   logic        wr_op, carry_op, legal_op, halt_op;
   logic [15:0] sext_imm;
   logic [16:0] alu_wide;

   assign opc              = ir[15:12];
   assign rf_read_address1 = ir[9:8];
   assign rf_read_address2 = ir[7:6];
   assign rf_write_address = ir[11:10];
   assign rf_data_in       = result;
   assign sext_imm         = {{10{ir[5]}}, ir[5:0]};

   // Opcode classification
   always_comb begin
      wr_op    = 1'b0;
      carry_op = 1'b0;
      legal_op = 1'b1;
      halt_op  = 1'b0;
      case (opc)
         4'h0: ;
         4'h1, 4'h2, 4'h8: begin
            wr_op    = 1'b1;
            carry_op = 1'b1;
         end
         4'h3, 4'h4, 4'h5, 4'h6, 4'h7: wr_op = 1'b1;
`ifdef EXEC_SEQUENCER_SHIFT_EN
         4'h9, 4'hA: wr_op = 1'b1;
`endif
         4'hF: halt_op = 1'b1;
         default: legal_op = 1'b0;
      endcase
   end

   // ALU: bit 16 carries the carry (ADD/ADDI) or the borrow (SUB)
   always_comb begin
      alu_wide = '0;
      case (opc)
         4'h1: alu_wide = {1'b0, op_a} + {1'b0, op_b};
         4'h2: alu_wide = {1'b0, op_a} - {1'b0, op_b};
         4'h3: alu_wide = {1'b0, op_a & op_b};
         4'h4: alu_wide = {1'b0, op_a | op_b};
         4'h5: alu_wide = {1'b0, op_a ^ op_b};
         4'h6: alu_wide = {9'h000, ir[7:0]};
         4'h7: alu_wide = {1'b0, op_a};
         4'h8: alu_wide = {1'b0, op_a} + {1'b0, sext_imm};
`ifdef EXEC_SEQUENCER_SHIFT_EN
         4'h9: alu_wide = {1'b0, op_a << ir[3:0]};
         4'hA: alu_wide = {1'b0, op_a >> ir[3:0]};
`endif
         default: alu_wide = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= FETCH;
         ir         <= '0;
         op_a       <= '0;
         op_b       <= '0;
         result     <= '0;
         pc         <= '0;
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            FETCH: begin
               if (instr_valid) begin
                  ir <= instr;
                  pc <= pc + 8'd1;
               end
            end
            READ: begin
               op_a <= rf_data_out1;
               op_b <= rf_data_out2;
            end
            EXEC: begin
               if (wr_op) begin
                  result    <= alu_wide[15:0];
                  zero_flag <= (alu_wide[15:0] == 16'h0000);
                  if (carry_op) carry_flag <= alu_wide[16];
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      busy        = 1'b0;
      halted      = 1'b0;
      illegal     = 1'b0;
      rf_enabling = 1'b0;
      case (state)
         FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) state_nxt = READ;
         end
         READ: begin
            busy      = 1'b1;
            state_nxt = EXEC;
         end
         EXEC: begin
            busy      = 1'b1;
            illegal   = ~legal_op;
            state_nxt = halt_op ? HALTED : WB;
         end
         WB: begin
            busy        = 1'b1;
            // A reset landing in WB must not let the dropped instruction write
            rf_enabling = wr_op & rst_n;
            state_nxt   = FETCH;
         end
         HALTED: halted = 1'b1;
         default: state_nxt = FETCH;
      endcase
   end

endmodule
